usb_port_sequencer: RTL
=======================

// Module: usb_port_sequencer
// PURPOSE
//  Host root-port state machine. Sits after the rx status monitor (connection/resume event pulses, line
//  state) and before the tx line driver. Debounces attach, sequences bus reset, suspend and resume
//  signalling, and reports port status/interrupts to the host register block. Timing is in tickIn units.
// PARAMETERS
//  DEBOUNCE_TICKS  100  attach stable time before connect is reported
//  RESET_TICKS     50   SE0 duration for bus reset
//  RESUME_TICKS    20   K duration for resume signalling
//  RECOVERY_TICKS  10   idle after reset before port enable
//  CNT_W           8    tick counter width; must hold max(param)-1
// PORTS
//  clk                 in   1  clock
//  rst                 in   1  synchronous, active-high reset
//  tickIn              in   1  1-cycle timebase strobe (nominally 1 ms)
//  connectStateIn      in   2  00 disc, 01 low-speed, 10 full-speed, 11 treated as disc
//  connectionEventIn   in   1  1-cycle pulse on any connectStateIn change
//  resumeIntIn         in   1  1-cycle pulse on remote wakeup (K) detected
//  cmdResetIn          in   1  1-cycle pulse, request bus reset
//  cmdSuspendIn        in   1  1-cycle pulse, request suspend
//  cmdResumeIn         in   1  1-cycle pulse, request host resume
//  forceSE0Out         out  1  tx drives SE0
//  forceKOut           out  1  tx drives K
//  eopReqOut           out  1  1-cycle pulse: tx sends low-speed EOP ending resume
//  sofEnableOut        out  1  frame generator may send SOF/traffic
//  portEnabledOut      out  1  port enabled (ENABLED, SUSPENDED, RESUMING)
//  lowSpeedOut         out  1  latched speed of attached device
//  portStateOut        out  3  current state encoding (below)
//  connectIntOut       out  1  1-cycle pulse: debounce done
//  disconnectIntOut    out  1  1-cycle pulse: disconnect from post-debounce state
//  resetDoneIntOut     out  1  1-cycle pulse: reset+recovery done
//  wakeupIntOut        out  1  1-cycle pulse: remote wakeup seen in SUSPENDED
// BEHAVIOUR
//  States: 0 DISC, 1 DEBOUNCE, 2 CONNECTED, 3 RESETTING, 4 RECOVERY, 5 ENABLED, 6 SUSPENDED, 7 RESUMING.
//  Reset: state DISC, counter 0, lowSpeedOut 0, every output 0. rst mid-sequence aborts at once (SE0/K drop next edge).
//  Counter: cleared on each state entry; +1 per tickIn; timed exit on edge where tickIn=1 and count==N-1,
//   so residency spans N-1..N tick periods. No wrap: the counter never passes N-1.
//  DISC: connectStateIn 01/10 -> DEBOUNCE, latch lowSpeedOut=(01).
//  DEBOUNCE: connectionEventIn -> restart counter, relatch speed; line disc -> DISC, no interrupt;
//   timeout -> CONNECTED + connectIntOut.
//  CONNECTED: cmdResetIn -> RESETTING.
//  RESETTING: forceSE0Out=1; line state ignored; timeout -> RECOVERY.
//  RECOVERY: timeout -> ENABLED, relatch speed, resetDoneIntOut.
//  ENABLED: sofEnableOut=1; cmdResetIn -> RESETTING; cmdSuspendIn -> SUSPENDED.
//  SUSPENDED: resumeIntIn -> RESUMING + wakeupIntOut; cmdResumeIn -> RESUMING; cmdResetIn -> RESETTING.
//  RESUMING: forceKOut=1; line state ignored; timeout -> ENABLED + eopReqOut pulse.
//  Disconnect (line 00/11) in CONNECTED/RECOVERY/ENABLED/SUSPENDED -> DISC + disconnectIntOut, speed cleared.
//  Priority on the same edge: disconnect > cmdReset > cmdSuspend > cmdResume > resumeIntIn.
//  Commands invalid for the current state are dropped, never queued.
//  All outputs registered: state-decoded outputs valid the cycle after the transition edge; pulses are exactly 1 clk.
// TESTING  (DEBOUNCE=4, RESET=3, RESUME=2, RECOVERY=2)
//  Line 10, 5 ticks -> connectIntOut after 4th tick, state 2, lowSpeedOut 0.
//  Line 01, 2 ticks, then 10 -> counter restarts, lowSpeedOut 0, connect after 4 further ticks.
//  CONNECTED + cmdResetIn -> forceSE0Out for 3 ticks, 2 recovery ticks, resetDoneIntOut, sofEnableOut 1.
//  ENABLED, cmdSuspendIn, then resumeIntIn -> wakeupIntOut, forceKOut 2 ticks, eopReqOut, state 5.
//  SUSPENDED, cmdResetIn with line 00 same edge -> DISC + disconnectIntOut, no SE0.
//  rst during RESETTING -> state 0, forceSE0Out 0, all outputs 0 next cycle.

Source files
------------

// File: rtl/usb_port_sequencer_if.sv
// Port-sequencer signal bundle: rx-monitor events and host commands in,
// tx line controls, port status and interrupt pulses out.
interface usb_port_sequencer_if;
    // timebase and line status from the rx monitor
    logic       tickIn;
    logic [1:0] connectStateIn;
    logic       connectionEventIn;
    logic       resumeIntIn;
    // host register block commands
    logic       cmdResetIn;
    logic       cmdSuspendIn;
    logic       cmdResumeIn;
    // tx line driver controls
    logic       forceSE0Out;
    logic       forceKOut;
    logic       eopReqOut;
    // port status
    logic       sofEnableOut;
    logic       portEnabledOut;
    logic       lowSpeedOut;
    logic [2:0] portStateOut;
    // interrupt pulses
    logic       connectIntOut;
    logic       disconnectIntOut;
    logic       resetDoneIntOut;
    logic       wakeupIntOut;

    // sequencer side
    modport slave (
        input  tickIn, connectStateIn, connectionEventIn, resumeIntIn,
        input  cmdResetIn, cmdSuspendIn, cmdResumeIn,
        output forceSE0Out, forceKOut, eopReqOut,
        output sofEnableOut, portEnabledOut, lowSpeedOut, portStateOut,
        output connectIntOut, disconnectIntOut, resetDoneIntOut, wakeupIntOut
    );

    // environment / host side
    modport master (
        output tickIn, connectStateIn, connectionEventIn, resumeIntIn,
        output cmdResetIn, cmdSuspendIn, cmdResumeIn,
        input  forceSE0Out, forceKOut, eopReqOut,
        input  sofEnableOut, portEnabledOut, lowSpeedOut, portStateOut,
        input  connectIntOut, disconnectIntOut, resetDoneIntOut, wakeupIntOut
    );
endinterface

// File: rtl/usb_port_sequencer.sv
// Host root-port sequencer: debounces attach, times bus reset / recovery /
// resume signalling in tickIn units and reports port status and interrupts.
// All outputs are registered; pulses last exactly one clock.
module usb_port_sequencer #(
    parameter int unsigned DEBOUNCE_TICKS = 100,
    parameter int unsigned RESET_TICKS    = 50,
    parameter int unsigned RESUME_TICKS   = 20,
    parameter int unsigned RECOVERY_TICKS = 10,
    parameter int unsigned CNT_W          = 8
) (
    input logic               clk,
    input logic               rst,
    usb_port_sequencer_if.slave port
);

    typedef enum logic [2:0] {
        DISC      = 3'd0,
        DEBOUNCE  = 3'd1,
        CONNECTED = 3'd2,
        RESETTING = 3'd3,
        RECOVERY  = 3'd4,
        ENABLED   = 3'd5,
        SUSPENDED = 3'd6,
        RESUMING  = 3'd7
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] tickCnt;
    logic [CNT_W-1:0] tickLimit;
    logic             timed;
    logic             timeout;
    logic             restart;
    logic             lineAttached;
    logic             lineLow;

    logic lowSpeedQ, lowSpeedNext;
    logic forceSE0Q, forceSE0Next;
    logic forceKQ, forceKNext;
    logic eopReqQ, eopReqNext;
    logic sofEnableQ, sofEnableNext;
    logic portEnabledQ, portEnabledNext;
    logic connectIntQ, connectIntNext;
    logic disconnectIntQ, disconnectIntNext;
    logic resetDoneIntQ, resetDoneIntNext;
    logic wakeupIntQ, wakeupIntNext;

    // 11 is an illegal line state and counts as detached
    assign lineLow      = (port.connectStateIn == 2'b01);
    assign lineAttached = (port.connectStateIn == 2'b01) || (port.connectStateIn == 2'b10);
    assign timeout      = timed && port.tickIn && (tickCnt == tickLimit);

    // per-state timeout limit (N-1); untimed states never expire
    always_comb begin
        timed     = 1'b1;
        tickLimit = '0;
        case (state)
            DEBOUNCE:  tickLimit = CNT_W'(DEBOUNCE_TICKS - 1);
            RESETTING: tickLimit = CNT_W'(RESET_TICKS - 1);
            RECOVERY:  tickLimit = CNT_W'(RECOVERY_TICKS - 1);
            RESUMING:  tickLimit = CNT_W'(RESUME_TICKS - 1);
            default:   timed = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= DISC;
        else     state <= stateNext;
    end

    // next-state logic; disconnect outranks every command, commands rank reset > suspend > resume > wakeup
    always_comb begin
        stateNext = state;
        restart   = 1'b0;
        case (state)
            DISC: begin
                if (lineAttached) stateNext = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!lineAttached)               stateNext = DISC;
                else if (port.connectionEventIn) restart   = 1'b1;
                else if (timeout)                stateNext = CONNECTED;
            end
            CONNECTED: begin
                if (!lineAttached)        stateNext = DISC;
                else if (port.cmdResetIn) stateNext = RESETTING;
            end
            RESETTING: begin
                if (timeout) stateNext = RECOVERY;
            end
            RECOVERY: begin
                if (!lineAttached) stateNext = DISC;
                else if (timeout)  stateNext = ENABLED;
            end
            ENABLED: begin
                if (!lineAttached)          stateNext = DISC;
                else if (port.cmdResetIn)   stateNext = RESETTING;
                else if (port.cmdSuspendIn) stateNext = SUSPENDED;
            end
            SUSPENDED: begin
                if (!lineAttached)         stateNext = DISC;
                else if (port.cmdResetIn)  stateNext = RESETTING;
                else if (port.cmdResumeIn) stateNext = RESUMING;
                else if (port.resumeIntIn) stateNext = RESUMING;
            end
            RESUMING: begin
                if (timeout) stateNext = ENABLED;
            end
            default: stateNext = DISC;
        endcase
    end

    // tick counter: cleared on every state entry and debounce restart, saturates at the limit
    always_ff @(posedge clk) begin
        if (rst || (stateNext != state) || restart) begin
            tickCnt <= '0;
        end else if (timed && port.tickIn && (tickCnt != tickLimit)) begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    // output decode from the upcoming state so the registered outputs line up with the state register
    always_comb begin
        lowSpeedNext = lowSpeedQ;
        if (stateNext == DISC) begin
            lowSpeedNext = 1'b0;
        end else if ((state == DISC) || restart || ((state == RECOVERY) && (stateNext == ENABLED))) begin
            lowSpeedNext = lineLow;
        end
        forceSE0Next      = (stateNext == RESETTING);
        forceKNext        = (stateNext == RESUMING);
        sofEnableNext     = (stateNext == ENABLED);
        portEnabledNext   = (stateNext inside {ENABLED, SUSPENDED, RESUMING});
        eopReqNext        = (state == RESUMING) && (stateNext == ENABLED);
        connectIntNext    = (state == DEBOUNCE) && (stateNext == CONNECTED);
        disconnectIntNext = (stateNext == DISC) &&
                            (state inside {CONNECTED, RECOVERY, ENABLED, SUSPENDED});
        resetDoneIntNext  = (state == RECOVERY) && (stateNext == ENABLED);
        // a host resume on the same edge takes the transition, so no wakeup is reported
        wakeupIntNext     = (state == SUSPENDED) && (stateNext == RESUMING) && !port.cmdResumeIn;
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lowSpeedQ      <= 1'b0;
            forceSE0Q      <= 1'b0;
            forceKQ        <= 1'b0;
            eopReqQ        <= 1'b0;
            sofEnableQ     <= 1'b0;
            portEnabledQ   <= 1'b0;
            connectIntQ    <= 1'b0;
            disconnectIntQ <= 1'b0;
            resetDoneIntQ  <= 1'b0;
            wakeupIntQ     <= 1'b0;
        end else begin
            lowSpeedQ      <= lowSpeedNext;
            forceSE0Q      <= forceSE0Next;
            forceKQ        <= forceKNext;
            eopReqQ        <= eopReqNext;
            sofEnableQ     <= sofEnableNext;
            portEnabledQ   <= portEnabledNext;
            connectIntQ    <= connectIntNext;
            disconnectIntQ <= disconnectIntNext;
            resetDoneIntQ  <= resetDoneIntNext;
            wakeupIntQ     <= wakeupIntNext;
        end
    end

    assign port.portStateOut     = state;
    assign port.lowSpeedOut      = lowSpeedQ;
    assign port.forceSE0Out      = forceSE0Q;
    assign port.forceKOut        = forceKQ;
    assign port.eopReqOut        = eopReqQ;
    assign port.sofEnableOut     = sofEnableQ;
    assign port.portEnabledOut   = portEnabledQ;
    assign port.connectIntOut    = connectIntQ;
    assign port.disconnectIntOut = disconnectIntQ;
    assign port.resetDoneIntOut  = resetDoneIntQ;
    assign port.wakeupIntOut     = wakeupIntQ;

endmodule
